add_accumulator: RTL and testbench
==================================

Name: add_accumulator

Overview:
- Parametrised successor to the team's 12-bit unsigned adder-with-carry.
- Sums a frame of COUNT unsigned WIDTH-bit operands, presented serially over a valid/ready stream.
- Returns the frame sum with a sticky overflow flag through an output valid/ready handshake.
- Used in the synth datapath to mix or accumulate voice and sample values without a tree of combinational adders.

Parameters:
- WIDTH, 12, operand and result width in bits (>=2).
- COUNT, 4, operands per frame (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  unsigned operand.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts an operand this cycle.
- out_data  output  WIDTH  frame sum (wrapped or saturated).
- out_overflow  output  1  frame sum exceeded 2^WIDTH-1.
- out_valid  output  1  out_data/out_overflow hold a completed frame.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset/clock: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, out_data=0, out_overflow=0, out_valid=0. in_ready=0 during any cycle with rst high.
- Accept event: in_valid & in_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: sum = {1'b0,acc} + {1'b0,in_data}, computed at WIDTH+1 bits.
  - acc <= sum[WIDTH-1:0]; ovf <= ovf | sum[WIDTH] (sticky within the frame); cnt <= cnt+1.
- Frame completion, when accepting with cnt==COUNT-1:
  - out_data <= acc+in_data (low WIDTH bits, or per the optional feature).
  - out_overflow <= ovf | carry.
  - out_valid <= 1; acc, cnt, ovf cleared; state <= HOLD.
- Latency: result registered and visible the cycle after the last operand is accepted.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data and out_overflow stable while out_valid=1.
  - On out_valid & out_ready: out_valid <= 0, state <= ACCUM. The next operand can be accepted the following cycle.
- in_valid low cycles (gaps) leave acc, cnt and ovf unchanged; the result is independent of gap timing.
- Maximum throughput: one frame per COUNT+1 cycles with out_ready tied high.
- COUNT=1: each operand passes through; out_overflow always 0.
- cnt width: $clog2(COUNT) bits, minimum 1. cnt never exceeds COUNT-1.
- Reset mid-frame or in HOLD: partial sum and pending result discarded; all outputs return to reset values on the next edge.
- Carry never leaks into out_data; only the low WIDTH bits are kept.

Optional Feature:
- Macro: ADD_ACCUMULATOR_SATURATE_EN.
- Defined: once ovf is set in a frame, acc is forced to {WIDTH{1'b1}} and stays there for the remainder of the frame. out_data = 2^WIDTH-1 whenever out_overflow=1.
- Not defined: modulo-2^WIDTH wrap; out_data is the low WIDTH bits of the true sum.
- out_overflow behaviour and timing are identical in both builds.

Test Plan:
- WIDTH=12, COUNT=4: operands 100, 200, 300, 400 back-to-back, out_ready=1 -> out_data=1000 (0x3E8), out_overflow=0, out_valid high one cycle after the 4th accept, for exactly one cycle.
- Operands 0xFFF, 0x001, 0x002, 0x003:
  - without macro -> out_data=0x005, out_overflow=1;
  - with ADD_ACCUMULATOR_SATURATE_EN -> out_data=0xFFF, out_overflow=1.
- Frame 1, 2, 3, 4 with out_ready held low 5 cycles after completion -> out_valid stays 1, out_data=10 stable, in_ready=0 throughout. After the out_ready handshake, the next frame 5, 5, 5, 5 -> 20 (overflow cleared from prior frame).
- Operands 100, 200, 300, 400 with 2-cycle in_valid gaps between each -> identical result to scenario 1 (0x3E8, overflow 0).
- Assert rst for one cycle after two operands (0x800, 0x800) accepted, then frame 1, 1, 1, 1 -> out_data=4, out_overflow=0; no result emitted for the aborted frame.
- WIDTH=8, COUNT=1: operand 0xAB -> out_data=0xAB, out_overflow=0, out_valid the following cycle.

Source files
------------

// File: rtl/add_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : add_accumulator_if
//  Description : Operand-in / frame-sum-out valid/ready stream bundle for
//                add_accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
interface add_accumulator_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_overflow, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_overflow, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : add_accumulator
//  Description : Serial sum of COUNT unsigned WIDTH-bit operands per frame,
//                with a sticky overflow flag. Define
//                ADD_ACCUMULATOR_SATURATE_EN to saturate instead of wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module add_accumulator #(
    parameter int WIDTH = 12,
    parameter int COUNT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    add_accumulator_if.slave  bus
);
    localparam int                 c_cnt_w    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(COUNT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [0:0] c_st_accum = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_ovf;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_last    = (r_cnt == c_cnt_last);
    assign w_release = w_out_valid & bus.out_ready;

    assign w_sum     = {1'b0, r_acc} + {1'b0, bus.in_data};
    assign w_ovf_nxt = r_ovf | w_sum[WIDTH];

`ifdef ADD_ACCUMULATOR_SATURATE_EN
    // Once overflowed, pin the running sum at full scale for the rest of the frame.
    assign w_acc_nxt = w_ovf_nxt ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_acc_nxt = w_sum[WIDTH-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_accum;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_accum: if (w_accept && w_last) w_state_nxt = c_st_hold;
            c_st_hold:  if (w_release)          w_state_nxt = c_st_accum;
            default:                            w_state_nxt = c_st_accum;
        endcase
    end

    // Output logic; in_ready is masked by rst so nothing is taken during reset
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_st_accum: w_in_ready  = ~rst;
            c_st_hold:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Frame datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_out_data <= w_acc_nxt;
                r_out_ovf  <= w_ovf_nxt;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_acc      <= w_acc_nxt;
                r_ovf      <= w_ovf_nxt;
                r_cnt      <= r_cnt + c_cnt_one;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_overflow = r_out_ovf;
endmodule
`default_nettype wire

// File: tb/tb_add_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_accumulator
//  Description : Scoreboard bench for add_accumulator (12-bit x4 and 8-bit x1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_add_accumulator;
    typedef struct {
        logic [11:0] d;
        logic        o;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t mon_e_a;
    exp_t mon_e_b;

`ifdef ADD_ACCUMULATOR_SATURATE_EN
    localparam logic [11:0] c_ovf_sum = 12'hFFF;
`else
    localparam logic [11:0] c_ovf_sum = 12'h005;
`endif

    add_accumulator_if #(.WIDTH(12)) bus_a ();
    add_accumulator_if #(.WIDTH(8))  bus_b ();

    add_accumulator #(.WIDTH(12), .COUNT(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    add_accumulator #(.WIDTH(8), .COUNT(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [11:0] d, input logic o);
        exp_t e;
        e.d = d;
        e.o = o;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [11:0] d, input logic o);
        exp_t e;
        e.d = d;
        e.o = o;
        exp_b.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send_a(input logic [11:0] d);
        int n;
        n = 0;
        bus_a.in_data  = d;
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_a.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_a_ready", 32'(bus_a.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        bus_b.in_data  = d;
        bus_b.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_b.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_b_ready", 32'(bus_b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic gap(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Monitors: a result is consumed when valid & ready are seen before the edge
    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            if (exp_a.size() == 0) begin
                check("unexpected_a", 32'd1, 32'd0);
            end else begin
                mon_e_a = exp_a.pop_front();
                check("data_a", 32'(bus_a.out_data), 32'(mon_e_a.d));
                check("ovf_a", 32'(bus_a.out_overflow), 32'(mon_e_a.o));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.out_valid && bus_b.out_ready) begin
            if (exp_b.size() == 0) begin
                check("unexpected_b", 32'd1, 32'd0);
            end else begin
                mon_e_b = exp_b.pop_front();
                check("data_b", 32'(bus_b.out_data), 32'(mon_e_b.d));
                check("ovf_b", 32'(bus_b.out_overflow), 32'(mon_e_b.o));
            end
        end
    end

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus_a.in_data   = '0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.in_data   = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_data", 32'(bus_a.out_data), 32'd0);
        check("rst_out_ovf", 32'(bus_a.out_overflow), 32'd0);
        check("rst_b_in_ready", 32'(bus_b.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back frame, result the cycle after the last accept, for one cycle
        push_a(12'd1000, 1'b0);
        send_a(12'd100);
        send_a(12'd200);
        send_a(12'd300);
        send_a(12'd400);
        @(negedge clk);
        check("s1_latency_valid", 32'(bus_a.out_valid), 32'd1);
        @(negedge clk);
        check("s1_valid_one_cycle", 32'(bus_a.out_valid), 32'd0);
        check("s1_ready_again", 32'(bus_a.in_ready), 32'd1);
        gap(1);

        // Carry out of the first add
        push_a(c_ovf_sum, 1'b1);
        send_a(12'hFFF);
        send_a(12'h001);
        send_a(12'h002);
        send_a(12'h003);
        gap(2);

        // Downstream stall holds the result
        bus_a.out_ready = 1'b0;
        push_a(12'd10, 1'b0);
        send_a(12'd1);
        send_a(12'd2);
        send_a(12'd3);
        send_a(12'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus_a.out_valid), 32'd1);
            check("hold_data", 32'(bus_a.out_data), 32'd10);
            check("hold_in_ready", 32'(bus_a.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;
        gap(2);
        push_a(12'd20, 1'b0);
        send_a(12'd5);
        send_a(12'd5);
        send_a(12'd5);
        send_a(12'd5);
        gap(2);

        // Gaps between operands do not change the sum
        push_a(12'h3E8, 1'b0);
        send_a(12'd100);
        gap(2);
        send_a(12'd200);
        gap(2);
        send_a(12'd300);
        gap(2);
        send_a(12'd400);
        gap(3);

        // Reset mid-frame after an overflowing partial sum
        send_a(12'h800);
        send_a(12'h800);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_a(12'd4, 1'b0);
        send_a(12'd1);
        send_a(12'd1);
        send_a(12'd1);
        send_a(12'd1);
        gap(2);

        // Single-operand frames pass straight through
        push_b(12'hAB, 1'b0);
        send_b(8'hAB);
        @(negedge clk);
        check("b_latency_valid", 32'(bus_b.out_valid), 32'd1);
        gap(1);
        push_b(12'hFF, 1'b0);
        send_b(8'hFF);
        gap(2);

        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("drain_a", 32'(exp_a.size()), 32'd0);
        check("drain_b", 32'(exp_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
